// File: rtl/gshare_branch_pred_pkg.sv
// Shared front-end constants and branch-predictor bus payloads.
package gshare_branch_pred_pkg;

    localparam int unsigned core_peval_width = 2;
    localparam int unsigned core_pc_width    = 32;
    localparam int unsigned core_hist_len    = 8;

    // Resolved-branch feedback as carried between execute and the predictor.
    typedef struct packed {
        logic                     valid;
        logic [core_pc_width-1:0] pc;
        logic [core_hist_len-1:0] hist;
        logic                     taken;
        logic                     mispred;
    } bp_fb_t;

    typedef struct packed {
        logic                     valid;
        logic                     taken;
        logic                     eval_alt;
        logic [core_hist_len-1:0] hist;
    } bp_rsp_t;

endpackage

// File: rtl/gshare_branch_pred_entry_update.sv
// Next-state of one predictor entry: saturating direction and confidence counters.
module bp_entry_update #(
    parameter int unsigned ctr_width  = 2,
    parameter int unsigned conf_width = 3
) (
    input  logic [ctr_width-1:0]  ctr,
    input  logic [conf_width-1:0] conf,
    input  logic                  taken,
    output logic [ctr_width-1:0]  ctr_next_c,
    output logic [conf_width-1:0] conf_next_c
);

    always_comb begin
        ctr_next_c  = ctr;
        conf_next_c = conf;
        if (taken) begin
            if (ctr != '1) ctr_next_c = ctr + ctr_width'(1);
        end else begin
            if (ctr != '0) ctr_next_c = ctr - ctr_width'(1);
        end
        // Confidence tracks how often the old prediction was right; any miss clears it.
        if (ctr[ctr_width-1] == taken) begin
            if (conf != '1) conf_next_c = conf + conf_width'(1);
        end else begin
            conf_next_c = '0;
        end
    end

endmodule

// File: rtl/gshare_branch_pred.sv
// Multi-port gshare direction predictor with confidence, history repair and init sweep.
module gshare_branch_pred
    import gshare_branch_pred_pkg::*;
#(
    parameter int unsigned port_cnt        = core_peval_width,
    parameter int unsigned pc_width        = core_pc_width,
    parameter int unsigned table_size      = 256,
    parameter int unsigned hist_len        = core_hist_len,
    parameter int unsigned ctr_width       = 2,
    parameter int unsigned conf_width      = 3,
    parameter int unsigned eval_alt_thresh = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                ready,
    input  logic                req_valid    [port_cnt],
    input  logic [pc_width-1:0] req_pc       [port_cnt],
    output logic                rsp_valid    [port_cnt],
    output logic                rsp_taken    [port_cnt],
    output logic                rsp_eval_alt [port_cnt],
    output logic [hist_len-1:0] rsp_hist     [port_cnt],
    input  logic                fb_valid,
    input  logic [pc_width-1:0] fb_pc,
    input  logic [hist_len-1:0] fb_hist,
    input  logic                fb_taken,
    input  logic                fb_mispred
);

    localparam int unsigned idx_w = $clog2(table_size);

    typedef logic [idx_w-1:0]      idx_t;
    typedef logic [ctr_width-1:0]  ctr_t;
    typedef logic [conf_width-1:0] conf_t;
    typedef logic [hist_len-1:0]   hist_t;
    typedef struct packed {
        ctr_t  ctr;
        conf_t conf;
    } entry_t;
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam ctr_t ctr_weak_nt = ctr_t'(2 ** (ctr_width - 1) - 1);

    if (table_size < 4 || (table_size & (table_size - 1)) != 0) begin : g_bad_table_size
        $error("table_size must be a power of two and at least 4");
    end
    if (hist_len < 2 || hist_len > idx_w) begin : g_bad_hist_len
        $error("hist_len must be between 2 and log2(table_size)");
    end
    if (ctr_width < 2) begin : g_bad_ctr_width
        $error("ctr_width must be at least 2");
    end
    if (eval_alt_thresh > 2 ** conf_width - 1) begin : g_bad_thresh
        $error("eval_alt_thresh exceeds the confidence counter range");
    end

    entry_t bp_table [table_size];
    state_t state;
    idx_t   init_idx;
    hist_t  ghr;

    entry_t rd_entry [port_cnt];
    logic   pred     [port_cnt];
    logic   alt      [port_cnt];
    hist_t  ghr_spec;
    idx_t   fb_idx;
    entry_t fb_entry;
    ctr_t   upd_ctr;
    conf_t  upd_conf;
    logic   run_active;
    logic   wr_en;
    idx_t   wr_idx;
    entry_t wr_data;
    logic   unused_bits;

    assign run_active = (state == ST_RUN) && en;

    // Lookups share the current GHR; valid ports shift predictions in, port 0 first.
    always_comb begin
        ghr_spec = ghr;
        for (int i = 0; i < port_cnt; i++) begin
            rd_entry[i] = bp_table[req_pc[i][idx_w+1:2] ^ idx_t'(ghr)];
            pred[i]     = rd_entry[i].ctr[ctr_width-1];
            alt[i]      = rd_entry[i].conf < conf_t'(eval_alt_thresh);
            if (req_valid[i]) ghr_spec = {ghr_spec[hist_len-2:0], pred[i]};
        end
    end

    assign fb_idx   = fb_pc[idx_w+1:2] ^ idx_t'(fb_hist);
    assign fb_entry = bp_table[fb_idx];

    bp_entry_update #(
        .ctr_width  (ctr_width),
        .conf_width (conf_width)
    ) u_entry_update (
        .ctr         (fb_entry.ctr),
        .conf        (fb_entry.conf),
        .taken       (fb_taken),
        .ctr_next_c  (upd_ctr),
        .conf_next_c (upd_conf)
    );

    // Single write port: init sweep owns it in INIT, feedback in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = init_idx;
        wr_data = '{ctr: ctr_weak_nt, conf: '0};
        if (!rst) begin
            if (state == ST_INIT) begin
                wr_en = 1'b1;
            end else if (run_active && fb_valid) begin
                wr_en   = 1'b1;
                wr_idx  = fb_idx;
                wr_data = '{ctr: upd_ctr, conf: upd_conf};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) bp_table[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
            ghr      <= '0;
            ready    <= 1'b0;
            for (int i = 0; i < port_cnt; i++) begin
                rsp_valid[i]    <= 1'b0;
                rsp_taken[i]    <= 1'b0;
                rsp_eval_alt[i] <= 1'b0;
                rsp_hist[i]     <= '0;
            end
        end else begin
            case (state)
                ST_INIT: begin
                    init_idx <= init_idx + idx_t'(1);
                    for (int i = 0; i < port_cnt; i++) rsp_valid[i] <= 1'b0;
                    if (init_idx == idx_t'(table_size - 1)) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    if (en) begin
                        for (int i = 0; i < port_cnt; i++) begin
                            rsp_valid[i]    <= req_valid[i];
                            rsp_taken[i]    <= pred[i];
                            rsp_eval_alt[i] <= alt[i];
                            rsp_hist[i]     <= ghr;
                        end
                        // Repair wins over the speculative shift.
                        if (fb_valid && fb_mispred) ghr <= {fb_hist[hist_len-2:0], fb_taken};
                        else                        ghr <= ghr_spec;
                    end else begin
                        for (int i = 0; i < port_cnt; i++) rsp_valid[i] <= 1'b0;
                    end
                end
            endcase
        end
    end

    // PC bits outside the index window and the low counter bits are intentionally unused.
    always_comb begin
        unused_bits = ^fb_pc;
        for (int i = 0; i < port_cnt; i++) begin
            unused_bits = unused_bits ^ (^req_pc[i]) ^ (^rd_entry[i]);
        end
    end

endmodule

// File: tb/tb_gshare_branch_pred.sv
// Directed bench for gshare_branch_pred: init sweep, training, saturation, history and control.
module tb_gshare_branch_pred;

    logic        clk;
    logic        rst;
    logic        en;
    logic        ready;
    logic        req_valid    [2];
    logic [31:0] req_pc       [2];
    logic        rsp_valid    [2];
    logic        rsp_taken    [2];
    logic        rsp_eval_alt [2];
    logic [3:0]  rsp_hist     [2];
    logic        fb_valid;
    logic [31:0] fb_pc;
    logic [3:0]  fb_hist;
    logic        fb_taken;
    logic        fb_mispred;

    int vectors;
    int miscompares;

    gshare_branch_pred #(
        .port_cnt        (2),
        .pc_width        (32),
        .table_size      (16),
        .hist_len        (4),
        .ctr_width       (2),
        .conf_width      (3),
        .eval_alt_thresh (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .ready        (ready),
        .req_valid    (req_valid),
        .req_pc       (req_pc),
        .rsp_valid    (rsp_valid),
        .rsp_taken    (rsp_taken),
        .rsp_eval_alt (rsp_eval_alt),
        .rsp_hist     (rsp_hist),
        .fb_valid     (fb_valid),
        .fb_pc        (fb_pc),
        .fb_hist      (fb_hist),
        .fb_taken     (fb_taken),
        .fb_mispred   (fb_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_fb(input logic v, input logic [31:0] pc, input logic [3:0] h,
                          input logic t, input logic m);
        fb_valid   = v;
        fb_pc      = pc;
        fb_hist    = h;
        fb_taken   = t;
        fb_mispred = m;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        en           = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        req_pc[0]    = 32'h0;
        req_pc[1]    = 32'h0;
        set_fb(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

        // Reset values
        tick();
        tick();
        chk("rst_ready", ready, 0);
        chk("rst_valid0", rsp_valid[0], 0);
        chk("rst_valid1", rsp_valid[1], 0);
        chk("rst_taken0", rsp_taken[0], 0);
        chk("rst_alt0", rsp_eval_alt[0], 0);
        chk("rst_hist0", rsp_hist[0], 0);

        // Init sweep: requests and feedback must be ignored
        rst          = 1'b0;
        req_valid[0] = 1'b1;
        req_pc[0]    = 32'h40;
        set_fb(1'b1, 32'h40, 4'h0, 1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("init_ready", ready, (k == 16) ? 1 : 0);
            chk("init_valid", rsp_valid[0], 0);
        end
        set_fb(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

        // First lookup at 0x40 sees a fresh weakly-not-taken entry
        tick();
        chk("first_valid0", rsp_valid[0], 1);
        chk("first_valid1", rsp_valid[1], 0);
        chk("first_taken", rsp_taken[0], 0);
        chk("first_alt", rsp_eval_alt[0], 1);
        chk("first_hist", rsp_hist[0], 0);
        req_valid[0] = 1'b0;

        // Training: 5 taken feedbacks -> ctr 11, conf 4
        set_fb(1'b1, 32'h40, 4'h0, 1'b1, 1'b0);
        repeat (5) tick();
        set_fb(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        req_valid[0] = 1'b1;
        req_pc[0]    = 32'h40;
        tick();
        chk("train_taken", rsp_taken[0], 1);
        chk("train_alt", rsp_eval_alt[0], 0);
        chk("train_hist", rsp_hist[0], 0);
        req_valid[0] = 1'b0;

        // Saturation then one not-taken -> ctr 10, conf 0; GHR is now 0001
        set_fb(1'b1, 32'h40, 4'h0, 1'b1, 1'b0);
        repeat (10) tick();
        set_fb(1'b1, 32'h40, 4'h0, 1'b0, 1'b0);
        tick();
        set_fb(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        req_valid[0] = 1'b1;
        req_pc[0]    = 32'h44;
        tick();
        chk("sat_taken", rsp_taken[0], 1);
        chk("sat_alt", rsp_eval_alt[0], 1);
        chk("sat_hist", rsp_hist[0], 4'h1);
        req_valid[0] = 1'b0;

        // Repair GHR to zero via a mispredict at an unrelated entry
        set_fb(1'b1, 32'h3C, 4'h0, 1'b0, 1'b1);
        tick();
        set_fb(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

        // Speculative history: port0 taken, port1 not-taken -> GHR 0010
        req_valid[0] = 1'b1;
        req_pc[0]    = 32'h40;
        req_valid[1] = 1'b1;
        req_pc[1]    = 32'h48;
        tick();
        chk("spec_valid0", rsp_valid[0], 1);
        chk("spec_valid1", rsp_valid[1], 1);
        chk("spec_taken0", rsp_taken[0], 1);
        chk("spec_taken1", rsp_taken[1], 0);
        chk("spec_hist0", rsp_hist[0], 0);
        chk("spec_hist1", rsp_hist[1], 0);
        req_valid[1] = 1'b0;
        req_pc[0]    = 32'h48;
        tick();
        chk("spec_ghr", rsp_hist[0], 4'h2);
        chk("spec_ghr_taken", rsp_taken[0], 1);

        // Repair collision with GHR 0101: lookup sees the old entry, GHR -> 1011
        req_pc[0] = 32'h40;
        set_fb(1'b1, 32'h40, 4'h5, 1'b1, 1'b1);
        tick();
        set_fb(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("coll_taken_old", rsp_taken[0], 0);
        chk("coll_hist", rsp_hist[0], 4'h5);
        chk("coll_alt", rsp_eval_alt[0], 1);
        req_pc[0] = 32'h38;
        tick();
        chk("repair_ghr", rsp_hist[0], 4'hB);
        chk("repair_taken_new", rsp_taken[0], 1);

        // en=0: no responses, GHR (0111) and table untouched
        en           = 1'b0;
        req_valid[1] = 1'b1;
        set_fb(1'b1, 32'h40, 4'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("dis_valid0", rsp_valid[0], 0);
            chk("dis_valid1", rsp_valid[1], 0);
        end
        en           = 1'b1;
        req_valid[1] = 1'b0;
        set_fb(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        req_pc[0] = 32'h40;
        tick();
        chk("en_valid", rsp_valid[0], 1);
        chk("en_hist", rsp_hist[0], 4'h7);
        chk("en_taken", rsp_taken[0], 0);

        // Reset in the middle of the sweep restarts it from index 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("mid_ready", ready, 0);
        end
        rst = 1'b1;
        tick();
        chk("rerst_ready", ready, 0);
        chk("rerst_valid", rsp_valid[0], 0);
        chk("rerst_hist", rsp_hist[0], 0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("reinit_ready", ready, (k == 16) ? 1 : 0);
        end
        req_valid[1] = 1'b1;
        req_pc[1]    = 32'h40;
        tick();
        chk("post_valid0", rsp_valid[0], 1);
        chk("post_valid1", rsp_valid[1], 1);
        chk("post_taken0", rsp_taken[0], 0);
        chk("post_taken1", rsp_taken[1], 0);
        chk("post_alt0", rsp_eval_alt[0], 1);
        chk("post_hist0", rsp_hist[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
